// File: rtl/video_timing_gen.sv
`default_nettype none
//==============================================================================
// Module   : video_timing_gen
// Brief    : Raster timing generator and test-pattern source for an HDMI/DVI
//            transmitter. All pixel, sync and marker outputs are registered
//            and refer to the same pixel.
// Revision : 1.0 - initial release
//==============================================================================
module video_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   BAR_W    = 80
) (
    input  logic        pixclk,
    input  logic        rst,
    input  logic [1:0]  pat_sel,
    input  logic [23:0] solid_rgb,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        vde,
    output logic [3:0]  cntrl,
    output logic        frame_start,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y
);

    localparam int         c_H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         c_V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] c_H_LAST       = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST       = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_ACT        = 10'(H_ACTIVE);
    localparam logic [9:0] c_V_ACT        = 10'(V_ACTIVE);
    localparam logic [9:0] c_HS_START     = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_HS_END       = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_VS_START     = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_VS_END       = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] c_BAR_LAST     = 10'(BAR_W - 1);
    localparam logic [2:0] c_BAR_IDX_MAX  = 3'd7;

    localparam logic [1:0] c_PAT_BARS     = 2'd0;
    localparam logic [1:0] c_PAT_CHECK    = 2'd1;
    localparam logic [1:0] c_PAT_RAMP     = 2'd2;
    localparam logic [1:0] c_PAT_SOLID    = 2'd3;

    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic [9:0]  r_bar_sub;
    logic [2:0]  r_bar_idx;
    logic [1:0]  r_pat_sel;
    logic [23:0] r_solid_rgb;

    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_origin;
    logic        w_active;
    logic        w_hs_act;
    logic        w_vs_act;
    logic [1:0]  w_pat;
    logic [23:0] w_solid;
    logic [7:0]  w_check;
    logic [7:0]  w_red;
    logic [7:0]  w_green;
    logic [7:0]  w_blue;

    assign w_h_wrap = (r_h_cnt == c_H_LAST);
    assign w_v_wrap = (r_v_cnt == c_V_LAST);
    assign w_origin = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
    assign w_active = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
    assign w_hs_act = (r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END);
    assign w_vs_act = (r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END);

    // The origin pixel already uses the value being latched, so a whole frame
    // is always drawn with one pattern selection.
    assign w_pat    = w_origin ? pat_sel   : r_pat_sel;
    assign w_solid  = w_origin ? solid_rgb : r_solid_rgb;
    assign w_check  = (r_h_cnt[5] ^ r_v_cnt[5]) ? 8'h00 : 8'hFF;

    assign cntrl    = 4'b0000;

    always_ff @(posedge pixclk) begin
        if (rst) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
        end else if (w_h_wrap) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    // Bar position tracked incrementally so no divider is needed.
    always_ff @(posedge pixclk) begin
        if (rst || w_h_wrap) begin
            r_bar_sub <= 10'd0;
            r_bar_idx <= 3'd0;
        end else if (r_bar_sub == c_BAR_LAST) begin
            r_bar_sub <= 10'd0;
            if (r_bar_idx != c_BAR_IDX_MAX) begin
                r_bar_idx <= r_bar_idx + 3'd1;
            end
        end else begin
            r_bar_sub <= r_bar_sub + 10'd1;
        end
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            r_pat_sel   <= 2'd0;
            r_solid_rgb <= 24'd0;
        end else if (w_origin) begin
            r_pat_sel   <= pat_sel;
            r_solid_rgb <= solid_rgb;
        end
    end

    always_comb begin
        w_red   = 8'h00;
        w_green = 8'h00;
        w_blue  = 8'h00;
        if (w_active) begin
            case (w_pat)
                c_PAT_BARS: begin
                    w_red   = {8{~r_bar_idx[1]}};
                    w_green = {8{~r_bar_idx[2]}};
                    w_blue  = {8{~r_bar_idx[0]}};
                end
                c_PAT_CHECK: begin
                    w_red   = w_check;
                    w_green = w_check;
                    w_blue  = w_check;
                end
                c_PAT_RAMP: begin
                    w_red   = r_h_cnt[9:2];
                    w_green = r_h_cnt[9:2];
                    w_blue  = r_h_cnt[9:2];
                end
                c_PAT_SOLID: begin
                    w_red   = w_solid[23:16];
                    w_green = w_solid[15:8];
                    w_blue  = w_solid[7:0];
                end
                default: begin
                    w_red   = 8'h00;
                    w_green = 8'h00;
                    w_blue  = 8'h00;
                end
            endcase
        end
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            red         <= 8'h00;
            green       <= 8'h00;
            blue        <= 8'h00;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            vde         <= 1'b0;
            frame_start <= 1'b0;
            pix_x       <= 10'd0;
            pix_y       <= 10'd0;
        end else begin
            red         <= w_red;
            green       <= w_green;
            blue        <= w_blue;
            hsync       <= w_hs_act ? HS_POL : ~HS_POL;
            vsync       <= w_vs_act ? VS_POL : ~VS_POL;
            vde         <= w_active;
            frame_start <= w_origin;
            pix_x       <= r_h_cnt;
            pix_y       <= r_v_cnt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
//==============================================================================
// Module   : tb_video_timing_gen
// Brief    : Directed self-checking bench for video_timing_gen; default
//            horizontal timing with a shortened 42-line frame.
// Revision : 1.0 - initial release
//==============================================================================
module tb_video_timing_gen;

    localparam int c_FRAME = 800 * 42;

    logic        pixclk;
    logic        rst;
    logic [1:0]  pat_sel;
    logic [23:0] solid_rgb;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        hsync;
    logic        vsync;
    logic        vde;
    logic [3:0]  cntrl;
    logic        frame_start;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;

    int n_total = 0;
    int n_pass  = 0;

    video_timing_gen #(
        .H_ACTIVE (640),
        .H_FP     (16),
        .H_SYNC   (96),
        .H_BP     (48),
        .V_ACTIVE (36),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (2),
        .HS_POL   (1'b0),
        .VS_POL   (1'b0),
        .BAR_W    (80)
    ) dut (
        .pixclk      (pixclk),
        .rst         (rst),
        .pat_sel     (pat_sel),
        .solid_rgb   (solid_rgb),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hsync       (hsync),
        .vsync       (vsync),
        .vde         (vde),
        .cntrl       (cntrl),
        .frame_start (frame_start),
        .pix_x       (pix_x),
        .pix_y       (pix_y)
    );

    initial pixclk = 1'b0;
    always #5 pixclk = ~pixclk;

    task automatic tick();
        @(posedge pixclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rgb"},   {8'h0, red, green, blue}, 32'h0);
        check({tag, "_vde"},   {31'h0, vde}, 32'h0);
        check({tag, "_hsync"}, {31'h0, hsync}, 32'h1);
        check({tag, "_vsync"}, {31'h0, vsync}, 32'h1);
        check({tag, "_fs"},    {31'h0, frame_start}, 32'h0);
        check({tag, "_x"},     {22'h0, pix_x}, 32'h0);
        check({tag, "_y"},     {22'h0, pix_y}, 32'h0);
        check({tag, "_cntrl"}, {28'h0, cntrl}, 32'h0);
    endtask

    initial begin
        int vde_line0;
        int hs_low;
        int hs_first;
        int vs_low;
        int vs_first;
        int fs_cnt;
        int solid_ok;
        int blank_nz;

        rst       = 1'b1;
        pat_sel   = 2'd0;
        solid_rgb = 24'h0;
        vde_line0 = 0;
        hs_low    = 0;
        hs_first  = -1;
        vs_low    = 0;
        vs_first  = -1;
        fs_cnt    = 0;
        solid_ok  = 0;
        blank_nz  = 0;

        repeat (3) tick();
        check_reset_state("por");
        rst = 1'b0;

        // Frame 1: colour bars, line/frame timing, pattern change at line 20.
        for (int k = 0; k < c_FRAME; k++) begin
            tick();
            if (k == 0) begin
                check("first_x",  {22'h0, pix_x}, 32'd0);
                check("first_y",  {22'h0, pix_y}, 32'd0);
                check("first_vde", {31'h0, vde}, 32'd1);
                check("first_fs", {31'h0, frame_start}, 32'd1);
                check("first_rgb", {8'h0, red, green, blue}, 32'hFFFFFF);
            end
            if (k == 79)  check("bar_px79",  {8'h0, red, green, blue}, 32'hFFFFFF);
            if (k == 80)  check("bar_px80",  {8'h0, red, green, blue}, 32'hFFFF00);
            if (k == 320) check("bar_px320", {8'h0, red, green, blue}, 32'hFF00FF);
            if (k == 639) begin
                check("bar_px639", {8'h0, red, green, blue}, 32'h000000);
                check("vde_px639", {31'h0, vde}, 32'd1);
            end
            if (k == 640) begin
                check("rgb_px640", {8'h0, red, green, blue}, 32'h000000);
                check("vde_px640", {31'h0, vde}, 32'd0);
            end
            if (k < 800) begin
                if (vde) vde_line0++;
                if (!hsync) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = k;
                end
            end
            if (!vsync) begin
                vs_low++;
                if (vs_first < 0) vs_first = k;
            end
            if (frame_start) fs_cnt++;
            if (k == 20 * 800) pat_sel = 2'd2;
            if (k == 20 * 800 + 80) check("midframe_bars", {8'h0, red, green, blue}, 32'hFFFF00);
        end
        check("vde_line_len",  vde_line0, 640);
        check("hsync_len",     hs_low, 96);
        check("hsync_start",   hs_first, 656);
        check("vsync_len",     vs_low, 1600);
        check("vsync_start",   vs_first, 38 * 800);
        check("fs_per_frame",  fs_cnt, 1);

        // Frame 2: grey ramp now in effect.
        tick();
        check("f2_fs",  {31'h0, frame_start}, 32'd1);
        check("f2_x",   {22'h0, pix_x}, 32'd0);
        check("f2_y",   {22'h0, pix_y}, 32'd0);
        repeat (400) tick();
        check("ramp_x400_pos", {22'h0, pix_x}, 32'd400);
        check("ramp_x400", {8'h0, red, green, blue}, 32'h646464);
        repeat (100) tick();
        check("pre_rst_x", {22'h0, pix_x}, 32'd500);

        // Mid-frame reset, restarting with the checkerboard.
        rst     = 1'b1;
        pat_sel = 2'd1;
        repeat (3) tick();
        check_reset_state("midrst");
        rst = 1'b0;
        tick();
        check("rst_restart_fs", {31'h0, frame_start}, 32'd1);
        check("rst_restart_xy", {12'h0, pix_x, pix_y}, 32'd0);
        check("chk_0_0",  {8'h0, red, green, blue}, 32'hFFFFFF);
        repeat (32) tick();
        check("chk_32_0", {8'h0, red, green, blue}, 32'h000000);
        repeat (32 * 800) tick();
        check("chk_pos",   {12'h0, pix_x, pix_y}, {12'h0, 10'd32, 10'd32});
        check("chk_32_32", {8'h0, red, green, blue}, 32'hFFFFFF);

        // Solid colour; a later solid_rgb change must not leak into the frame.
        rst       = 1'b1;
        pat_sel   = 2'd3;
        solid_rgb = 24'h123456;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 800; k++) begin
            tick();
            if (k == 0) begin
                check("solid_fs", {31'h0, frame_start}, 32'd1);
                solid_rgb = 24'hABCDEF;
                pat_sel   = 2'd0;
            end
            if (vde && {red, green, blue} == 24'h123456) solid_ok++;
            if (!vde && {red, green, blue} != 24'h0) blank_nz++;
        end
        check("solid_line", solid_ok, 640);
        check("blank_zero", blank_nz, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing and test-pattern source that drives the HDMI/DVI transmitter's pixel inputs (`red`, `green`, `blue`, `hsync`, `vsync`, `vde`, `cntrl`). It counts horizontal and vertical positions for a parameterised video mode, which defaults to 640x480@60 with an 800x525 total. It emits sync and data-enable signals, plus one of four selectable test patterns. All outputs are registered and mutually aligned, so the transmitter can consume them directly on `pixclk`.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, active lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch
- `HS_POL`, 0, hsync active level (0 = active-low)
- `VS_POL`, 0, vsync active level (0 = active-low)
- `BAR_W`, 80, colour-bar width in pixels (`H_ACTIVE`/8)

Ports:
- `pixclk`  in  1  pixel clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `pat_sel`  in  2  pattern: 0 colour bars, 1 checkerboard, 2 grey ramp, 3 solid
- `solid_rgb`  in  24  solid colour {R,G,B} for pattern 3
- `red`, `green`, `blue`  out  8 each  pixel components
- `hsync`, `vsync`  out  1 each  syncs at the configured polarity
- `vde`  out  1  video data enable
- `cntrl`  out  4  control bits; constant 4'b0000
- `frame_start`  out  1  one-cycle pulse aligned with pixel (0,0)
- `pix_x`, `pix_y`  out  10 each  coordinate of the current output pixel

## Operation
- `H_TOTAL` = `H_ACTIVE`+`H_FP`+`H_SYNC`+`H_BP` (800). `V_TOTAL` = `V_ACTIVE`+`V_FP`+`V_SYNC`+`V_BP` (525).
- Counters:
  - `h_cnt` runs 0..`H_TOTAL`-1 and wraps to 0.
  - `v_cnt` increments only when `h_cnt` wraps. It runs 0..`V_TOTAL`-1 and wraps to 0.
  - Both counters are 10-bit unsigned.
- Decode from the counters:
  - Active region: `h_cnt`<`H_ACTIVE` && `v_cnt`<`V_ACTIVE`.
  - hsync active: `H_ACTIVE`+`H_FP` <= `h_cnt` < `H_ACTIVE`+`H_FP`+`H_SYNC` (656..751).
  - vsync active: `V_ACTIVE`+`V_FP` <= `v_cnt` < `V_ACTIVE`+`V_FP`+`V_SYNC` (490..491). vsync changes level together with `h_cnt`=0.
- Pattern latch:
  - `pat_sel` and `solid_rgb` are sampled into shadow registers only when `h_cnt`=0 && `v_cnt`=0.
  - Changes mid-frame take effect at the next frame. No tearing is permitted.
- Colour bars:
  - A bar sub-counter runs 0..`BAR_W`-1. The bar index runs 0..7.
  - Both clear at `h_cnt`=0. The index increments when the sub-counter wraps and saturates at 7.
  - R = {8{~idx[1]}}, G = {8{~idx[2]}}, B = {8{~idx[0]}}.
  - The bar order is white, yellow, cyan, green, magenta, red, blue, black.
  - Division by `BAR_W` is not used.
- Checkerboard: all channels 8'hFF when `h_cnt`[5]^`v_cnt`[5]=0, else 8'h00 (32x32 squares).
- Grey ramp: all channels = `h_cnt`[9:2].
- Solid: R,G,B = the latched `solid_rgb`[23:16], [15:8], [7:0].
- Outside the active region, `red`/`green`/`blue` = 0 regardless of pattern.
- Reset values:
  - `h_cnt`, `v_cnt`, bar counters = 0.
  - Shadow `pat_sel` = 0; shadow `solid_rgb` = 0.
  - `red`/`green`/`blue` = 0, `vde` = 0, `frame_start` = 0, `pix_x`/`pix_y` = 0, `cntrl` = 0.
  - `hsync` = ~`HS_POL`; `vsync` = ~`VS_POL` (both inactive).
- Reset asserted mid-frame: on the next edge all registers take their reset values. The first non-reset edge restarts at pixel (0,0).

## Timing
- Pipeline: one register stage. At each non-reset edge:
  - Output registers load the values decoded from the current (`h_cnt`,`v_cnt`).
  - The counters advance on the same edge.
- Output latency is 1 cycle from counter to pins. `red`, `green`, `blue`, `hsync`, `vsync`, `vde`, `pix_x`, `pix_y` and `frame_start` always refer to the same pixel.
- After `rst` deasserts, the first non-reset edge produces pixel (0,0) with `vde`=1 and `frame_start`=1.
- `frame_start` repeats every `H_TOTAL`*`V_TOTAL` = 420000 cycles.
- A `pat_sel` change becomes visible at the `frame_start` pixel following the sample point. It is never visible earlier.
- Throughput is one pixel per `pixclk` with no stalls; there is no handshake.

## Test plan
- Reset release, default parameters:
  - First output cycle: `pix_x`=0, `pix_y`=0, `vde`=1, `frame_start`=1, RGB = FF/FF/FF (white bar).
  - `vde` high for exactly 640 consecutive cycles per active line.
- Line timing: `hsync` is low for exactly 96 cycles, starting 656 cycles after the start of each line. The line period is 800 cycles. Across a full frame, `vsync` is low for 1600 cycles starting at line 490.
- Colour bars:
  - Pixels 79/80 are white/yellow (FFFF00), pixel 320 is magenta (FF00FF), pixel 639 is black.
  - Pixel 640 is RGB 0 with `vde`=0.
- Mid-frame pattern change: `pat_sel` 0→2 asserted at line 100. Line 100 still shows bars. After the next `frame_start`, pixel x=400 shows grey 8'd100 on all channels.
- Solid plus checkerboard:
  - Pattern 3 with `solid_rgb`=24'h123456 gives every active pixel 12/34/56.
  - Pattern 1 gives pixel (32,0) = 00 and pixel (32,32) = FF.
- Reset mid-operation: assert `rst` for 3 cycles at pixel (500,300). Outputs go to reset values, with `hsync`=`vsync`=1. The first non-reset cycle shows (0,0) with `frame_start`=1.
